// File: rtl/dm_bridge.sv
// dm_bridge: data-side responder for the CPU MEM-stage port.
// Serves a byte-enabled data RAM and a three-register count-down timer
// that raises irq. Reads are combinational; writes commit on the clock edge.
module dm_bridge #(
  parameter int          DM_WORDS = 3072,
  parameter logic [31:0] TC_BASE  = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  output logic [31:0] m_data_rdata,
  output logic        irq
);

  localparam int          AW       = $clog2(DM_WORDS);
  localparam logic [29:0] DM_LIMIT = 30'(DM_WORDS);
  localparam logic [29:0] TC_WBASE = TC_BASE[31:2];

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CNT, ST_INT} tc_state_t;

  // Byte-lane merge of write data into an existing word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

  // Word-address decode; the byte offset bits never take part.
  logic [29:0]   addr_w;
  logic [29:0]   tc_diff;
  logic [1:0]    tc_off;
  logic [AW-1:0] ram_idx;
  logic          ram_hit, tc_hit;
  logic          ram_wr, ctrl_wr, preset_wr;
  logic          unused_bits;

  assign addr_w      = m_data_addr[31:2];
  assign tc_diff     = addr_w - TC_WBASE;
  assign tc_off      = tc_diff[1:0];
  assign ram_idx     = m_data_addr[AW+1:2];
  assign ram_hit     = addr_w < DM_LIMIT;
  assign tc_hit      = (addr_w >= TC_WBASE) && (addr_w < TC_WBASE + 30'd3);
  assign unused_bits = ^{m_data_addr[1:0], tc_diff[29:2]};

  // Timer registers only accept full-word writes; COUNT is read-only.
  assign ram_wr    = ram_hit && (m_data_byteen != 4'h0);
  assign ctrl_wr   = tc_hit && (m_data_byteen == 4'hF) && (tc_off == 2'd0);
  assign preset_wr = tc_hit && (m_data_byteen == 4'hF) && (tc_off == 2'd1);

  // RAM storage plus a per-word written map: clearing the map on reset
  // makes every word read as zero without touching the storage array.
  logic [31:0]         mem [DM_WORDS];
  logic [DM_WORDS-1:0] wvalid;
  logic [31:0]         ram_word;

  assign ram_word = wvalid[ram_idx] ? mem[ram_idx] : 32'h0;

  // RAM data write; a word's first write merges into zero.
  always_ff @(posedge clk) begin
    if (ram_wr) mem[ram_idx] <= merge_bytes(ram_word, m_data_wdata, m_data_byteen);
  end

  // Written-word map, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       wvalid          <= '0;
    else if (ram_wr) wvalid[ram_idx] <= 1'b1;
  end

  // Timer state.
  tc_state_t   state, state_n;
  logic [3:0]  ctrl;
  logic [31:0] preset, count, count_n;
  logic        flag;
  logic        fsm_en_clr, flag_set, flag_clr;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next state and timer actions; decisions use registered CTRL only, so a
  // CPU CTRL write is seen by the FSM one edge later.
  always_comb begin
    state_n    = state;
    count_n    = count;
    fsm_en_clr = 1'b0;
    flag_set   = 1'b0;
    flag_clr   = 1'b0;
    case (state)
      ST_IDLE: if (ctrl[0]) state_n = ST_LOAD;
      ST_LOAD: begin
        count_n = preset;
        state_n = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl[0]) begin
          state_n = ST_IDLE;
        end else if (count > 32'd1) begin
          count_n = count - 32'd1;
        end else begin
          count_n  = 32'h0;
          flag_set = 1'b1;
          state_n  = ST_INT;
        end
      end
      ST_INT: begin
        if (ctrl[2:1] == 2'b01) begin
          flag_clr = 1'b1;
          state_n  = ST_LOAD;
        end else begin
          fsm_en_clr = 1'b1;
          state_n    = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Timer registers; a CPU CTRL write overrides the FSM's EN clear and
  // clears the interrupt flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl   <= 4'h0;
      preset <= 32'h0;
      count  <= 32'h0;
      flag   <= 1'b0;
    end else begin
      count <= count_n;
      if (preset_wr) preset <= m_data_wdata;
      if (ctrl_wr)         ctrl    <= m_data_wdata[3:0];
      else if (fsm_en_clr) ctrl[0] <= 1'b0;
      if (ctrl_wr)       flag <= 1'b0;
      else if (flag_set) flag <= 1'b1;
      else if (flag_clr) flag <= 1'b0;
    end
  end

  assign irq = flag & ctrl[3];

  // Combinational read mux; misses return zero.
  always_comb begin
    m_data_rdata = 32'h0;
    if (ram_hit) begin
      m_data_rdata = ram_word;
    end else if (tc_hit) begin
      case (tc_off)
        2'd0:    m_data_rdata = {28'h0, ctrl};
        2'd1:    m_data_rdata = preset;
        2'd2:    m_data_rdata = count;
        default: m_data_rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_bridge.sv
// tb_dm_bridge: directed timer sequences and randomized RAM traffic for
// dm_bridge, checked against expectations derived in the bench.
module tb_dm_bridge;

  localparam logic [31:0] TC = 32'h0000_7F00;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_data_rdata;
  logic        irq;

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] ram_m [3072];

  dm_bridge dut (
    .clk           (clk),
    .reset         (reset),
    .m_data_addr   (m_data_addr),
    .m_data_wdata  (m_data_wdata),
    .m_data_byteen (m_data_byteen),
    .m_data_rdata  (m_data_rdata),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    m_data_addr   = a;
    m_data_wdata  = d;
    m_data_byteen = be;
    @(posedge clk);
    #1;
    m_data_byteen = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    m_data_addr   = a;
    m_data_byteen = 4'h0;
    #1;
    d = m_data_rdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    logic [31:0] r, d, a;
    logic [3:0]  be;
    int          idx;
    bit          exp_irq;

    reset         = 1'b1;
    m_data_addr   = 32'h0;
    m_data_wdata  = 32'h0;
    m_data_byteen = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("reset_rdata_ram0", m_data_rdata, 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    rd(TC, r);       chk("reset_ctrl", r, 32'h0);
    rd(TC + 8, r);   chk("reset_count", r, 32'h0);
    reset = 1'b0;
    step();

    // Randomized RAM traffic against a word-array model with byte merge.
    foreach (ram_m[i]) ram_m[i] = 32'h0;
    for (int n = 0; n < 80; n++) begin
      idx = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15))
                                        : 3056 + int'($urandom_range(0, 15));
      a  = (32'(idx) << 2) | 32'($urandom_range(0, 3));
      be = 4'($urandom_range(0, 15));
      d  = $urandom;
      if (be != 4'h0) begin
        wr(a, d, be);
        for (int b = 0; b < 4; b++)
          if (be[b]) ram_m[idx][8*b +: 8] = d[8*b +: 8];
      end
      rd(a, r);
      chk("ram_rand_same", r, ram_m[idx]);
      idx = int'($urandom_range(0, 15));
      rd(32'(idx) << 2, r);
      chk("ram_rand_other", r, ram_m[idx]);
      if (n % 8 == 0) begin
        a = 32'h0000_3000 + (32'($urandom_range(0, 255)) << 2);
        wr(a, $urandom, 4'hF);
        rd(a, r);
        chk("ram_rand_miss", r, 32'h0);
      end
      step();
    end

    // Byte merge
    pulse_reset();
    wr(32'h100, 32'h1122_3344, 4'hF);
    wr(32'h100, 32'hAA00_0000, 4'h8);
    rd(32'h100, r);  chk("byte_merge", r, 32'hAA22_3344);
    wr(32'h101, 32'h0000_5500, 4'h2);
    rd(32'h102, r);  chk("byte_merge_lsb_ignored", r, 32'hAA22_5544);

    // Out-of-range and last RAM word
    wr(32'h0, 32'h5A5A_5A5A, 4'hF);
    wr(32'h2FFC, 32'h1234_5678, 4'hF);
    wr(32'h3000, 32'hFFFF_FFFF, 4'hF);
    wr(TC + 32'h10, 32'hFFFF_FFFF, 4'hF);
    rd(32'h3000, r);       chk("miss_3000", r, 32'h0);
    rd(TC + 32'h10, r);    chk("miss_7f10", r, 32'h0);
    rd(TC + 32'hC, r);     chk("miss_7f0c", r, 32'h0);
    step();
    rd(32'h0, r);          chk("ram0_unchanged", r, 32'h5A5A_5A5A);
    rd(32'h2FFC, r);       chk("ram_last_word", r, 32'h1234_5678);
    rd(TC, r);             chk("ctrl_untouched", r, 32'h0);

    // One-shot: PRESET=5, CTRL=9 at edge E
    pulse_reset();
    wr(TC + 4, 32'd5, 4'hF);
    wr(TC, 32'h9, 4'hF);
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      rd(TC + 8, r);
      chk("oneshot_count", r, 32'(5 - k));
      chk("oneshot_irq_low", 32'(irq), 32'h0);
      step();
    end
    chk("oneshot_irq_E7", 32'(irq), 32'h1);
    rd(TC + 8, r);  chk("oneshot_count_zero", r, 32'h0);
    step();
    rd(TC, r);      chk("oneshot_en_cleared", r, 32'h8);
    chk("oneshot_irq_E8", 32'(irq), 32'h1);
    step();
    step();
    chk("oneshot_irq_held", 32'(irq), 32'h1);
    wr(TC, 32'h0, 4'hF);
    chk("oneshot_irq_cleared", 32'(irq), 32'h0);

    // Async reset mid-count at COUNT=2
    pulse_reset();
    wr(32'h100, 32'hCAFE_F00D, 4'hF);
    wr(TC + 4, 32'd5, 4'hF);
    wr(TC, 32'h9, 4'hF);
    repeat (5) step();
    rd(TC + 8, r);  chk("midreset_count_before", r, 32'd2);
    reset = 1'b1;
    #1;
    chk("midreset_irq", 32'(irq), 32'h0);
    rd(TC + 8, r);  chk("midreset_count", r, 32'h0);
    rd(TC, r);      chk("midreset_ctrl", r, 32'h0);
    rd(32'h100, r); chk("midreset_ram", r, 32'h0);
    reset = 1'b0;
    repeat (3) step();
    rd(TC + 8, r);  chk("midreset_stays_idle", r, 32'h0);

    // Auto-reload: PRESET=3, CTRL=0xB, PRESET=6 written mid-count at E+18
    pulse_reset();
    wr(TC + 4, 32'd3, 4'hF);
    wr(TC, 32'hB, 4'hF);
    for (int k = 1; k <= 38; k++) begin
      if (k == 18) wr(TC + 4, 32'd6, 4'hF);
      else         step();
      exp_irq = (k == 5) || (k == 10) || (k == 15) || (k == 20) || (k == 28) || (k == 36);
      chk($sformatf("reload_irq_E%0d", k), 32'(irq), 32'(exp_irq));
    end

    // PRESET=0 fires after E+3
    pulse_reset();
    wr(TC + 4, 32'd0, 4'hF);
    wr(TC, 32'h9, 4'hF);
    step();
    chk("preset0_irq_E1", 32'(irq), 32'h0);
    step();
    chk("preset0_irq_E2", 32'(irq), 32'h0);
    step();
    chk("preset0_irq_E3", 32'(irq), 32'h1);

    // Partial and read-only timer writes are dropped
    pulse_reset();
    wr(TC + 4, 32'd7, 4'hF);
    wr(TC + 4, 32'hDEAD_BEEF, 4'b0011);
    rd(TC + 4, r);  chk("partial_preset", r, 32'd7);
    wr(TC, 32'h1, 4'b0001);
    rd(TC, r);      chk("partial_ctrl", r, 32'h0);
    wr(TC + 8, 32'h55, 4'hF);
    rd(TC + 8, r);  chk("count_readonly", r, 32'h0);

    // Clearing EN during CNT freezes COUNT
    wr(TC, 32'h9, 4'hF);
    repeat (3) step();
    rd(TC + 8, r);  chk("clr_en_count_E3", r, 32'd6);
    wr(TC, 32'h8, 4'hF);
    rd(TC + 8, r);  chk("clr_en_count_E4", r, 32'd5);
    repeat (10) step();
    rd(TC + 8, r);  chk("clr_en_count_frozen", r, 32'd5);
    rd(TC, r);      chk("clr_en_ctrl", r, 32'h8);
    chk("clr_en_no_irq", 32'(irq), 32'h0);

    // Async reset drops a raised irq before the next edge
    pulse_reset();
    wr(TC + 4, 32'd1, 4'hF);
    wr(TC, 32'h9, 4'hF);
    repeat (3) step();
    chk("irq_before_reset", 32'(irq), 32'h1);
    reset = 1'b1;
    #1;
    chk("irq_async_drop", 32'(irq), 32'h0);
    reset = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dm_bridge.md
# dm_bridge

Data-side responder for the pipelined CPU's external memory port. Decodes the CPU's `m_data_addr` / `m_data_byteen` / `m_data_wdata` requests and returns `m_data_rdata` from one of two targets:

- a byte-enabled data RAM;
- a count-down timer peripheral, which raises `irq` toward the CPU's exception path.

It sits outside `mips`, at the other end of the CPU's MEM-stage data interface.

## Interface
Parameters:
- `DM_WORDS`, 3072: data RAM depth in 32-bit words; covers 0x0000_0000–0x0000_2FFF.
- `TC_BASE`, 32'h0000_7F00: timer register base; 3 words at offsets 0x0, 0x4, 0x8.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `m_data_addr` in 32: byte address from the CPU MEM stage.
- `m_data_wdata` in 32: write data, already lane-shifted by the CPU.
- `m_data_byteen` in 4: per-byte write strobes. Non-zero means write; 0 means read-only access.
- `m_data_rdata` out 32: read data, combinational from `m_data_addr`.
- `irq` out 1: timer interrupt request, level, registered.

## Operation
**Address decode** (uses `m_data_addr[31:2]`; bits [1:0] are ignored for decode):
- RAM hit: address < `DM_WORDS`*4.
- Timer hit: `TC_BASE` ≤ address < `TC_BASE`+12.
- Anything else misses. Writes to a miss are dropped; reads of a miss return 0.

**RAM:**
- Write: byte lane k of word `addr[13:2]` takes `m_data_wdata[8k+7:8k]` when `byteen[k]`=1.
- Read: the full word is returned unshifted. The CPU's BE unit does lane extraction.

**Timer registers:**
- CTRL (+0x0): bit 0 EN, bits [2:1] MODE, bit 3 IM. Other bits read 0.
- PRESET (+0x4): 32-bit reload value.
- COUNT (+0x8): read-only current count.
- Timer writes are accepted only when `byteen`=4'b1111; partial writes are dropped. Writes to COUNT are dropped.
- A CTRL write clears the interrupt flag.

**Timer FSM** (states IDLE, LOAD, CNT, INT):
- IDLE: if EN → LOAD.
- LOAD: COUNT←PRESET → CNT.
- CNT:
  - if !EN → IDLE, COUNT held;
  - else if COUNT>1: COUNT−1;
  - else COUNT←0, set flag → INT.
- INT:
  - MODE 2'b00 (one-shot): EN←0 → IDLE. Flag stays set until the next CTRL write.
  - MODE 2'b01 (auto-reload): → LOAD. Flag clears on the same edge, so it pulses one cycle.
  - MODE 2'b1x: behaves as 2'b00.
- `irq` = flag & IM.

**Conflict rules:**
- A CPU CTRL write and the FSM's EN clear on the same edge: the CPU value wins.
- A CPU CTRL write is also seen by the FSM on the next edge, not the same edge.
- A PRESET write during CNT does not affect the current count; it takes effect at the next LOAD.

## Timing
- Reads: zero latency; `m_data_rdata` is valid in the same cycle `m_data_addr` is driven. No handshake and no stalls.
- Writes: committed on the rising edge where `byteen`≠0. A read of the same address in the next cycle returns the new data.
- Timer latency, with CTRL written with EN=1 at edge E:
  - LOAD after E+1;
  - COUNT=PRESET after E+2;
  - INT and `irq` high after E+2+N for PRESET N≥1;
  - after E+3 for N=0.
- Reset, asynchronous, takes effect immediately:
  - all RAM words 0;
  - CTRL, PRESET, COUNT 0;
  - state IDLE, flag 0;
  - `irq`=0;
  - `m_data_rdata` reflects the reset contents.
- Reset asserted mid-count: the FSM returns to IDLE and `irq` drops without waiting for a clock.

## Test plan
- RAM byte merge:
  1. write 32'h11223344 to 0x100 with byteen 1111;
  2. write 32'hAA00_0000 with byteen 1000;
  3. read 0x100 → 32'hAA223344.
- Out-of-range:
  1. write 32'hFFFF_FFFF to 0x0000_3000 and to 0x0000_7F10;
  2. read both → 0;
  3. read RAM word 0 → unchanged.
- One-shot timer:
  1. PRESET=5;
  2. CTRL=32'h9 (EN=1, MODE 00, IM=1) at edge E;
  3. COUNT reads 5,4,3,2,1 after E+2..E+6;
  4. `irq`=1 after E+7 and stays high; EN reads 0;
  5. write CTRL=0 → `irq`=0 next cycle.
- Auto-reload:
  1. PRESET=3;
  2. CTRL=32'hB;
  3. `irq` is high exactly one cycle per period, every 5 cycles;
  4. writing PRESET=6 mid-count changes the period only from the next reload.
- Edge cases:
  - PRESET=0 with CTRL=32'h9 → INT after E+3;
  - partial write (byteen 0011) to PRESET → PRESET unchanged;
  - clearing EN during CNT → COUNT frozen, state IDLE, no `irq`.
- Async reset mid-count:
  1. pulse `reset` between clock edges while COUNT=2 and IM=1;
  2. `irq`, COUNT, CTRL and `m_data_rdata` (addr 0x100) are 0 before the next edge.
